accum_datapath: RTL and testbench

- Calculator datapath at the far end of the toggle-event interface driven by the calculator control FSM.
- The control FSM signals each command by inverting one of four level lines: store, update, show, reset. This block detects each inversion as one event.
- It executes the command on an accumulator with saturating add and selects the display value (operand or total).
- It converts the display value to packed BCD with a multicycle double-dabble engine for the 7-segment driver.

---
 rtl/accum_datapath.sv | 173 +++++++++++++++++
 tb/tb_accum_datapath.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/accum_datapath.sv
// rtl/accum_datapath.sv - toggle-event calculator datapath with saturating accumulator and BCD display
module accum_datapath #(
    parameter int N_WIDTH   = 8,
    parameter int ACC_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 store,
    input  logic                 update,
    input  logic                 show,
    input  logic                 reset,
    input  logic [N_WIDTH-1:0]   number,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 show_total,
    output logic                 overflow,
    output logic [15:0]          disp_bcd,
    output logic                 bcd_valid,
    output logic                 busy
);

    localparam int SR_W  = 16 + ACC_WIDTH;
    localparam int CNT_W = $clog2(ACC_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // previous toggle levels
    logic prev_store_q, prev_update_q, prev_show_q, prev_reset_q;

    // calculator state
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 overflow_q, overflow_d;
    logic                 show_total_q, show_total_d;

    // conversion engine state
    state_t               state_q, state_d;
    logic [SR_W-1:0]      sr_q, sr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] cvt_src_q, cvt_src_d;
    logic [15:0]          disp_bcd_q, disp_bcd_d;
    logic                 bcd_valid_q, bcd_valid_d;

    logic                 ev_store, ev_update, ev_show, ev_reset;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] disp_val;
    logic [SR_W-1:0]      sr_adj;
    logic [3:0]           nib;

    // a level change on any toggle line is one event
    always_comb begin
        ev_store  = store  ^ prev_store_q;
        ev_update = update ^ prev_update_q;
        ev_show   = show   ^ prev_show_q;
        ev_reset  = reset  ^ prev_reset_q;
    end

    // command execution: reset beats store, store beats update, show is independent
    always_comb begin
        acc_d        = acc_q;
        overflow_d   = overflow_q;
        show_total_d = show_total_q;
        sum          = {1'b0, acc_q} + (ACC_WIDTH + 1)'(number);
        if (ev_reset) begin
            acc_d        = '0;
            overflow_d   = 1'b0;
            show_total_d = 1'b0;
        end else begin
            if (ev_store) begin
                acc_d      = ACC_WIDTH'(number);
                overflow_d = 1'b0;
            end else if (ev_update) begin
                if (sum[ACC_WIDTH]) begin
                    acc_d      = '1;
                    overflow_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_WIDTH-1:0];
                end
            end
            if (ev_show) begin
                show_total_d = ~show_total_q;
            end
        end
    end

    // value that the display should currently show
    always_comb begin
        disp_val = show_total_q ? acc_q : ACC_WIDTH'(number);
    end

    // double-dabble conversion FSM: start, ACC_WIDTH shift steps, publish
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        cvt_src_d   = cvt_src_q;
        disp_bcd_d  = disp_bcd_q;
        bcd_valid_d = bcd_valid_q;
        sr_adj      = sr_q;
        nib         = '0;
        case (state_q)
            IDLE: begin
                if ((disp_val != cvt_src_q) || !bcd_valid_q) begin
                    cvt_src_d   = disp_val;
                    sr_d        = {16'b0, disp_val};
                    cnt_d       = CNT_W'(ACC_WIDTH);
                    bcd_valid_d = 1'b0;
                    state_d     = CONV;
                end
            end
            CONV: begin
                for (int i = 0; i < 4; i++) begin
                    nib = sr_q[ACC_WIDTH + 4*i +: 4];
                    if (nib >= 4'd5) begin
                        sr_adj[ACC_WIDTH + 4*i +: 4] = nib + 4'd3;
                    end
                end
                sr_d  = {sr_adj[SR_W-2:0], 1'b0};
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_bcd_d  = sr_q[SR_W-1:ACC_WIDTH];
                bcd_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state registers; reset captures the toggle levels so release creates no events
    always_ff @(posedge clk) begin
        prev_store_q  <= store;
        prev_update_q <= update;
        prev_show_q   <= show;
        prev_reset_q  <= reset;
        if (!rst_n) begin
            acc_q        <= '0;
            overflow_q   <= 1'b0;
            show_total_q <= 1'b0;
            state_q      <= IDLE;
            sr_q         <= '0;
            cnt_q        <= '0;
            cvt_src_q    <= '0;
            disp_bcd_q   <= 16'h0000;
            bcd_valid_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            overflow_q   <= overflow_d;
            show_total_q <= show_total_d;
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            cvt_src_q    <= cvt_src_d;
            disp_bcd_q   <= disp_bcd_d;
            bcd_valid_q  <= bcd_valid_d;
        end
    end

    assign acc_out    = acc_q;
    assign overflow   = overflow_q;
    assign show_total = show_total_q;
    assign disp_bcd   = disp_bcd_q;
    assign bcd_valid  = bcd_valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_accum_datapath.sv
// tb/tb_accum_datapath.sv - scoreboard bench for accum_datapath
module tb_accum_datapath;

    localparam int NW  = 8;
    localparam int AW  = 10;
    localparam int MAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          store, update, show, reset;
    logic [NW-1:0] number;
    logic [AW-1:0] acc_out;
    logic          show_total, overflow, bcd_valid, busy;
    logic [15:0]   disp_bcd;

    accum_datapath #(.N_WIDTH(NW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .store(store), .update(update), .show(show),
        .reset(reset), .number(number), .acc_out(acc_out), .show_total(show_total),
        .overflow(overflow), .disp_bcd(disp_bcd), .bcd_valid(bcd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] bcd;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    int   cyc = 0;
    int   m_acc, m_src, m_rem;
    bit   m_ovf, m_show, m_valid;
    bit   m_pst, m_pup, m_psh, m_prs;
    logic [15:0] m_disp, m_pend;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // behavioural model: command rules plus a conversion slot lasting AW+2 edges
    always @(posedge clk) begin
        int  dv, s;
        bit  e_st, e_up, e_sh, e_rs;
        cyc++;
        if (!rst_n) begin
            m_acc = 0; m_ovf = 0; m_show = 0;
            m_rem = 0; m_valid = 0; m_src = 0; m_disp = 0; m_pend = 0;
            exp_q.delete();
        end else begin
            e_st = store  != m_pst;
            e_up = update != m_pup;
            e_sh = show   != m_psh;
            e_rs = reset  != m_prs;
            dv = m_show ? m_acc : int'(number);
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_valid = 1;
                    m_disp  = m_pend;
                end
            end else if (dv != m_src || !m_valid) begin
                m_src   = dv;
                m_valid = 0;
                m_rem   = AW + 1;
                m_pend  = to_bcd(dv);
                exp_q.push_back('{m_pend, cyc + AW + 1});
            end
            if (e_rs) begin
                m_acc = 0; m_ovf = 0; m_show = 0;
            end else begin
                if (e_st) begin
                    m_acc = int'(number); m_ovf = 0;
                end else if (e_up) begin
                    s = m_acc + int'(number);
                    if (s > MAX) begin
                        m_acc = MAX; m_ovf = 1;
                    end else begin
                        m_acc = s;
                    end
                end
                if (e_sh) m_show = !m_show;
            end
        end
        m_pst = store; m_pup = update; m_psh = show; m_prs = reset;
    end

    // monitor: per-cycle state compare, and pop expected conversions on bcd_valid rise
    bit prev_bv = 0;
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            chk("acc_out",    int'(acc_out),    m_acc);
            chk("overflow",   int'(overflow),   int'(m_ovf));
            chk("show_total", int'(show_total), int'(m_show));
            chk("busy",       int'(busy),       int'(m_rem > 0));
            chk("bcd_valid",  int'(bcd_valid),  int'(m_valid));
            chk("disp_bcd",   int'(disp_bcd),   int'(m_disp));
            if (bcd_valid && !prev_bv) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_bcd",  int'(disp_bcd), int'(e.bcd));
                    chk("sb_time", cyc, e.due);
                end
            end
            prev_bv = bcd_valid;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 0; store = 0; update = 0; show = 0; reset = 0; number = 8'd37;
        tick(2);
        rst_n = 1;
        tick(11);
        chk("rel_busy_11", int'(busy), 1);
        chk("rel_valid_11", int'(bcd_valid), 0);
        tick(1);
        chk("rel_bcd_37", int'(disp_bcd), 16'h0037);
        chk("rel_valid_12", int'(bcd_valid), 1);
        chk("rel_acc", int'(acc_out), 0);

        number = 8'd200; store = ~store;
        tick(1);
        chk("store_200", int'(acc_out), 200);
        show = ~show;
        tick(1);
        chk("show_on", int'(show_total), 1);
        tick(12);
        chk("show_bcd_200", int'(disp_bcd), 16'h0200);
        tick(8);

        number = 8'd250;
        for (int k = 0; k < 4; k++) begin
            update = ~update;
            tick(1);
            chk("sat_acc", int'(acc_out), (k < 3) ? 450 + 250 * k : 1023);
            chk("sat_ovf", int'(overflow), (k < 3) ? 0 : 1);
            tick(19);
        end
        chk("sat_bcd_1023", int'(disp_bcd), 16'h1023);
        number = 8'd5; store = ~store;
        tick(1);
        chk("store5_acc", int'(acc_out), 5);
        chk("store5_ovf", int'(overflow), 0);

        number = 8'd200; store = ~store; tick(2);
        number = 8'd100; update = ~update; tick(2);
        chk("pre_sim_acc", int'(acc_out), 300);
        reset = ~reset; update = ~update; show = ~show;
        tick(1);
        chk("sim_acc", int'(acc_out), 0);
        chk("sim_show", int'(show_total), 0);
        chk("sim_ovf", int'(overflow), 0);
        number = 8'd7; store = ~store; update = ~update;
        tick(1);
        chk("st_up_acc", int'(acc_out), 7);

        number = 8'd20; update = ~update;
        tick(6);
        chk("held_acc", int'(acc_out), 27);
        tick(20);

        number = 8'd12;
        tick(3);
        number = 8'd99;
        tick(30);
        chk("mid_bcd_99", int'(disp_bcd), 16'h0099);

        number = 8'd55;
        tick(4);
        rst_n = 0; store = 1; update = 1; show = 1; reset = 1;
        tick(1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bcd", int'(disp_bcd), 0);
        chk("rst_valid", int'(bcd_valid), 0);
        tick(1);
        rst_n = 1;
        tick(1);
        chk("noev_acc", int'(acc_out), 0);
        chk("noev_show", int'(show_total), 0);
        tick(15);

        for (int c = 0; c < 600; c++) begin
            number = NW'($urandom);
            if ($urandom_range(0, 7) == 0)  store  = ~store;
            if ($urandom_range(0, 5) == 0)  update = ~update;
            if ($urandom_range(0, 15) == 0) show   = ~show;
            if ($urandom_range(0, 40) == 0) reset  = ~reset;
            rst_n = ($urandom_range(0, 150) != 0);
            if ($urandom_range(0, 3) == 0) tick(14);
            else tick(1);
        end
        rst_n = 1;
        tick(20);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
